vend_controller: RTL and testbench
==================================

Name: vend_controller

Overview:
- Downstream stage of the coin-input/debounce block in the vending-machine design.
- Consumes single-cycle coin-accepted events, keeps the customer's credit and handles purchase/cancel requests.
- Pulses a dispense strobe for the selected product.
- Returns change as a timed sequence of coin-ejection pulses: greedy 50/20/10/5.

Parameters:
- PRICE0, 15, price of product 0 (multiple of 5, 5..255)
- PRICE1, 25, price of product 1 (multiple of 5, 5..255)
- PRICE2, 40, price of product 2 (multiple of 5, 5..255)
- PRICE3, 55, price of product 3 (multiple of 5, 5..255)
- CHANGE_GAP, 4, clock cycles between successive change-coin pulses (>=2)

Ports:
- CLK100MHZ  input  1  system clock, all logic on rising edge
- CPU_RESETN  input  1  asynchronous active-low reset
- coin_valid  input  1  one-cycle pulse, coin accepted upstream
- coin_amt  input  8  value of that coin (5, 10, 20 or 50), sampled when coin_valid=1
- buy  input  1  one-cycle purchase request
- sel  input  2  product select, sampled when buy=1
- cancel  input  1  one-cycle request to refund all credit
- credit  output  8  current credit
- dispense  output  1  one-cycle dispense strobe
- dispense_id  output  2  product being dispensed, valid with dispense
- change_coin  output  4  one-hot coin ejection pulse: [0]=5, [1]=10, [2]=20, [3]=50
- coin_reject  output  1  one-cycle pulse, incoming coin refused (return it physically)
- short_credit  output  1  one-cycle pulse, buy refused for insufficient credit
- busy  output  1  high in VEND and CHANGE

Behaviour:
- Reset (asynchronous, CPU_RESETN=0): state=IDLE; credit=0; every output 0; gap counter=0; remaining-change register=0. Reset mid-CHANGE abandons outstanding change, with no further pulses.
- States:
  - IDLE: credit==0.
  - CREDIT: credit>0, accepting coins.
  - VEND: exactly 1 cycle.
  - CHANGE: multi-cycle.
- Coin accept (IDLE/CREDIT):
  - coin_valid=1 and credit+coin_amt<=255 -> credit updated next cycle; IDLE->CREDIT.
  - Sum >255 -> credit unchanged; coin_reject=1 next cycle.
  - coin_amt not in {5,10,20,50} -> rejected the same way.
- Coin in VEND/CHANGE: always rejected (coin_reject pulse), credit untouched.
- Buy (IDLE/CREDIT), price P = PRICEsel:
  - Priced against credit before any same-cycle coin.
  - credit>=P: next cycle enter VEND; dispense=1, dispense_id=sel; credit=credit-P (same-cycle coin, if accepted, is then added in the VEND cycle).
  - credit<P: short_credit=1 next cycle; state unchanged; same-cycle coin still processed normally.
- VEND exit: after its single cycle -> CHANGE if credit>0, else IDLE.
- Cancel (IDLE/CREDIT):
  - Next cycle enter CHANGE with remaining=credit (plus same-cycle accepted coin).
  - cancel+buy same cycle: cancel wins; buy ignored, no short_credit.
  - Cancel in IDLE with no coin: no-op.
- buy/cancel in VEND/CHANGE: ignored.
- CHANGE:
  - On entry, remaining=credit.
  - First coin pulse on the first CHANGE cycle; then one pulse every CHANGE_GAP cycles.
  - Each pulse is a greedy pick, largest of 50/20/10/5 <= remaining; remaining decremented by that value.
  - credit output tracks remaining.
  - If remaining<5 and nonzero (cannot occur with legal parameters), force remaining=0.
  - remaining==0 after a pulse -> IDLE on the following cycle.
- Output timing: all outputs registered. Pulse outputs (dispense, change_coin, coin_reject, short_credit) high exactly one cycle. change_coin is at most one bit set.
- Width: credit is 8-bit unsigned. Add is saturation-checked via the 9-bit sum; subtract only when credit>=P, so no wrap.

Test Plan:
- Reset: coins 10+5 (credit=15), then CPU_RESETN low mid-cycle -> credit=0, all outputs 0 immediately, state IDLE.
- Exact buy: coins 10,5; buy sel=0 (15) -> dispense=1, dispense_id=0 one cycle; credit=0; IDLE; no change_coin.
- Change: coins 50,20; buy sel=1 (25) -> dispense; credit=45; change_coin pulses 4'b0100, 4'b0100, 4'b0001 spaced 4 cycles; credit 25, 5, 0; then IDLE.
- Insufficient funds with simultaneous coin: credit=20; buy sel=2 (40) with coin 50 same cycle -> short_credit=1, credit=70; buy sel=2 again -> dispense, change 20,10 (4'b0100, 4'b0010).
- Overflow: credit=250 via five 50s; coin 10 -> coin_reject=1, credit=250; cancel -> five 4'b1000 pulses, then IDLE.
- Cancel vs buy same cycle, plus coin during CHANGE: credit=30; assert cancel and buy together -> no dispense; change 20,10; coin 5 during CHANGE -> coin_reject=1, change sequence unaltered.

Source files
------------

// File: rtl/vend_controller.sv
// Vending-machine credit/purchase controller: accumulates coin credit, dispenses
// products, and pays change back as spaced greedy 50/20/10/5 coin pulses.
module vend_controller #(
  parameter int unsigned PRICE0     = 15,
  parameter int unsigned PRICE1     = 25,
  parameter int unsigned PRICE2     = 40,
  parameter int unsigned PRICE3     = 55,
  parameter int unsigned CHANGE_GAP = 4
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       coin_valid,
  input  logic [7:0] coin_amt,
  input  logic       buy,
  input  logic [1:0] sel,
  input  logic       cancel,
  output logic [7:0] credit,
  output logic       dispense,
  output logic [1:0] dispense_id,
  output logic [3:0] change_coin,
  output logic       coin_reject,
  output logic       short_credit,
  output logic       busy
);

  localparam int unsigned GAP_W = $clog2(CHANGE_GAP);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(CHANGE_GAP - 1);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t           state, state_n;
  logic [7:0]       credit_n;
  logic [GAP_W-1:0] gap, gap_n;
  logic             dispense_n, reject_n, short_n, busy_n, do_pay;
  logic [1:0]       id_n;
  logic [3:0]       change_n;
  logic [7:0]       price, base, total, pay_amt;
  logic [8:0]       sum;
  logic             coin_legal, coin_ok, buy_ok;

  function automatic logic [7:0] price_of(input logic [1:0] s);
    case (s)
      2'd0:    return 8'(PRICE0);
      2'd1:    return 8'(PRICE1);
      2'd2:    return 8'(PRICE2);
      default: return 8'(PRICE3);
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    price      = price_of(sel);
    coin_legal = coin_amt inside {8'd5, 8'd10, 8'd20, 8'd50};
    buy_ok     = buy && !cancel && (credit >= price);
    // A purchase is priced against the old credit; a same-cycle coin lands on what is left.
    base       = buy_ok ? credit - price : credit;
    sum        = {1'b0, base} + {1'b0, coin_amt};
    coin_ok    = coin_valid && coin_legal && !sum[8];
    total      = coin_ok ? sum[7:0] : base;

    state_n    = state;
    credit_n   = credit;
    gap_n      = gap;
    dispense_n = 1'b0;
    id_n       = 2'd0;
    change_n   = 4'd0;
    reject_n   = 1'b0;
    short_n    = 1'b0;
    do_pay     = 1'b0;
    pay_amt    = credit;

    case (state)
      IDLE, CREDIT: begin
        reject_n = coin_valid && !coin_ok;
        if (cancel && total != 8'd0) begin
          do_pay  = 1'b1;
          pay_amt = total;
        end else if (buy_ok) begin
          state_n    = VEND;
          credit_n   = total;
          dispense_n = 1'b1;
          id_n       = sel;
        end else begin
          short_n  = buy && !cancel;
          credit_n = total;
          state_n  = (total != 8'd0) ? CREDIT : IDLE;
        end
      end
      VEND: begin
        reject_n = coin_valid;
        if (credit != 8'd0) do_pay = 1'b1;
        else                state_n = IDLE;
      end
      CHANGE: begin
        reject_n = coin_valid;
        if (credit == 8'd0)     state_n = IDLE;
        else if (gap != '0)     gap_n   = gap - GAP_W'(1);
        else                    do_pay  = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // Emit one greedy change coin; the first one goes out on entry to CHANGE.
    if (do_pay) begin
      state_n = CHANGE;
      gap_n   = GAP_RELOAD;
      if (pay_amt >= 8'd50) begin
        change_n = 4'b1000;
        credit_n = pay_amt - 8'd50;
      end else if (pay_amt >= 8'd20) begin
        change_n = 4'b0100;
        credit_n = pay_amt - 8'd20;
      end else if (pay_amt >= 8'd10) begin
        change_n = 4'b0010;
        credit_n = pay_amt - 8'd10;
      end else if (pay_amt >= 8'd5) begin
        change_n = 4'b0001;
        credit_n = pay_amt - 8'd5;
      end else begin
        credit_n = 8'd0;
      end
    end

    busy_n = (state_n == VEND) || (state_n == CHANGE);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state        <= IDLE;
      credit       <= 8'd0;
      gap          <= '0;
      dispense     <= 1'b0;
      dispense_id  <= 2'd0;
      change_coin  <= 4'd0;
      coin_reject  <= 1'b0;
      short_credit <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state        <= state_n;
      credit       <= credit_n;
      gap          <= gap_n;
      dispense     <= dispense_n;
      dispense_id  <= id_n;
      change_coin  <= change_n;
      coin_reject  <= reject_n;
      short_credit <= short_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Scenario bench for vend_controller: each test queues the expected registered
// outputs for every cycle it drives; a monitor pops and compares after each edge.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [7:0] coin_amt = 8'd0;
  logic       buy = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       cancel = 1'b0;
  logic [7:0] credit;
  logic       dispense;
  logic [1:0] dispense_id;
  logic [3:0] change_coin;
  logic       coin_reject;
  logic       short_credit;
  logic       busy;

  vend_controller dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .coin_valid  (coin_valid),
    .coin_amt    (coin_amt),
    .buy         (buy),
    .sel         (sel),
    .cancel      (cancel),
    .credit      (credit),
    .dispense    (dispense),
    .dispense_id (dispense_id),
    .change_coin (change_coin),
    .coin_reject (coin_reject),
    .short_credit(short_credit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cr;
    logic       disp;
    logic [1:0] id;
    logic [3:0] chg;
    logic       rej;
    logic       shrt;
    logic       bsy;
  } exp_t;

  typedef struct {
    string name;
    exp_t  e;
  } item_t;

  item_t sb[$];
  int    vectors = 0;
  int    miscompares = 0;
  exp_t  obs;

  assign obs = {credit, dispense, dispense_id, change_coin, coin_reject, short_credit, busy};

  function automatic exp_t ex(input logic [7:0] cr, input logic d, input logic [1:0] id,
                              input logic [3:0] ch, input logic rj, input logic sh, input logic bz);
    exp_t r;
    r.cr = cr; r.disp = d; r.id = id; r.chg = ch; r.rej = rj; r.shrt = sh; r.bsy = bz;
    return r;
  endfunction

  function automatic exp_t st(input logic [7:0] cr);
    return ex(cr, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic exp_t chg(input logic [7:0] cr, input logic [3:0] ch);
    return ex(cr, 1'b0, 2'd0, ch, 1'b0, 1'b0, 1'b1);
  endfunction

  // Scoreboard monitor: compares the oldest queued expectation just after each edge.
  always @(posedge clk) begin
    item_t it;
    #1;
    if (sb.size() != 0) begin
      it = sb.pop_front();
      vectors++;
      if (obs !== it.e) begin
        miscompares++;
        $display("FAIL %s: got cr=%0d disp=%b id=%0d chg=%b rej=%b short=%b busy=%b, want cr=%0d disp=%b id=%0d chg=%b rej=%b short=%b busy=%b",
                 it.name, obs.cr, obs.disp, obs.id, obs.chg, obs.rej, obs.shrt, obs.bsy,
                 it.e.cr, it.e.disp, it.e.id, it.e.chg, it.e.rej, it.e.shrt, it.e.bsy);
      end
    end
  end

  task automatic cyc(input string name, input logic cv, input logic [7:0] amt, input logic b,
                     input logic [1:0] s, input logic c, input exp_t e);
    coin_valid = cv; coin_amt = amt; buy = b; sel = s; cancel = c;
    sb.push_back('{name, e});
    @(posedge clk); #1;
    coin_valid = 1'b0; coin_amt = 8'd0; buy = 1'b0; sel = 2'd0; cancel = 1'b0;
  endtask

  task automatic coin(input string name, input logic [7:0] amt, input exp_t e);
    cyc(name, 1'b1, amt, 1'b0, 2'd0, 1'b0, e);
  endtask

  task automatic nop(input string name, input exp_t e);
    cyc(name, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, e);
  endtask

  task automatic quiet(input string name, input int n, input logic [7:0] cr);
    for (int i = 0; i < n; i++) nop(name, chg(cr, 4'd0));
  endtask

  task automatic test_reset;
    #3;
    vectors++;
    if (obs !== st(8'd0)) begin
      miscompares++;
      $display("FAIL reset_initial: got %h, want %h", obs, st(8'd0));
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    coin("rst_coin10", 8'd10, st(8'd10));
    coin("rst_coin5", 8'd5, st(8'd15));
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== st(8'd0)) begin
      miscompares++;
      $display("FAIL reset_async: got %h, want %h", obs, st(8'd0));
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    nop("post_reset_idle", st(8'd0));
  endtask

  task automatic test_exact_buy;
    coin("exact_coin10", 8'd10, st(8'd10));
    coin("exact_coin5", 8'd5, st(8'd15));
    cyc("exact_buy", 1'b0, 8'd0, 1'b1, 2'd0, 1'b0, ex(8'd0, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    // A coin offered during the VEND cycle is refused.
    coin("exact_coin_in_vend", 8'd5, ex(8'd0, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0));
    nop("exact_idle", st(8'd0));
  endtask

  task automatic test_change;
    coin("chg_coin50", 8'd50, st(8'd50));
    coin("chg_coin20", 8'd20, st(8'd70));
    cyc("chg_buy1", 1'b0, 8'd0, 1'b1, 2'd1, 1'b0, ex(8'd45, 1'b1, 2'd1, 4'd0, 1'b0, 1'b0, 1'b1));
    nop("chg_pulse20a", chg(8'd25, 4'b0100));
    quiet("chg_gap1", 3, 8'd25);
    nop("chg_pulse20b", chg(8'd5, 4'b0100));
    quiet("chg_gap2", 3, 8'd5);
    nop("chg_pulse5", chg(8'd0, 4'b0001));
    nop("chg_idle", st(8'd0));
  endtask

  task automatic test_short_credit;
    coin("short_coin20", 8'd20, st(8'd20));
    cyc("short_buy2_coin50", 1'b1, 8'd50, 1'b1, 2'd2, 1'b0, ex(8'd70, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0));
    cyc("short_rebuy2", 1'b0, 8'd0, 1'b1, 2'd2, 1'b0, ex(8'd30, 1'b1, 2'd2, 4'd0, 1'b0, 1'b0, 1'b1));
    nop("short_pulse20", chg(8'd10, 4'b0100));
    quiet("short_gap", 3, 8'd10);
    nop("short_pulse10", chg(8'd0, 4'b0010));
    nop("short_idle", st(8'd0));
  endtask

  task automatic test_overflow;
    logic [7:0] cr;
    cr = 8'd0;
    for (int i = 0; i < 5; i++) begin
      cr = cr + 8'd50;
      coin("ovf_coin50", 8'd50, st(cr));
    end
    coin("ovf_coin10_reject", 8'd10, ex(8'd250, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0));
    cyc("ovf_cancel", 1'b0, 8'd0, 1'b0, 2'd0, 1'b1, chg(8'd200, 4'b1000));
    cr = 8'd200;
    for (int i = 0; i < 4; i++) begin
      quiet("ovf_gap", 3, cr);
      cr = cr - 8'd50;
      nop("ovf_pulse50", chg(cr, 4'b1000));
    end
    nop("ovf_idle", st(8'd0));
  endtask

  task automatic test_cancel_vs_buy;
    coin("cvb_coin20", 8'd20, st(8'd20));
    coin("cvb_coin10", 8'd10, st(8'd30));
    cyc("cvb_cancel_buy", 1'b0, 8'd0, 1'b1, 2'd0, 1'b1, chg(8'd10, 4'b0100));
    coin("cvb_coin_in_change", 8'd5, ex(8'd10, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b1));
    quiet("cvb_gap", 2, 8'd10);
    nop("cvb_pulse10", chg(8'd0, 4'b0010));
    nop("cvb_idle", st(8'd0));
  endtask

  task automatic test_idle_corner_cases;
    coin("corner_illegal_coin7", 8'd7, ex(8'd0, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0));
    cyc("corner_cancel_idle", 1'b0, 8'd0, 1'b0, 2'd0, 1'b1, st(8'd0));
    cyc("corner_buy_empty", 1'b0, 8'd0, 1'b1, 2'd3, 1'b0, ex(8'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0));
    // Cancel together with a coin in IDLE refunds that coin straight away.
    cyc("corner_cancel_with_coin", 1'b1, 8'd10, 1'b0, 2'd0, 1'b1, chg(8'd0, 4'b0010));
    nop("corner_idle", st(8'd0));
  endtask

  task automatic test_reset_mid_change;
    coin("rmc_coin50", 8'd50, st(8'd50));
    coin("rmc_coin20", 8'd20, st(8'd70));
    cyc("rmc_cancel", 1'b0, 8'd0, 1'b0, 2'd0, 1'b1, chg(8'd20, 4'b1000));
    quiet("rmc_gap", 1, 8'd20);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== st(8'd0)) begin
      miscompares++;
      $display("FAIL reset_mid_change: got %h, want %h", obs, st(8'd0));
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) nop("rmc_no_more_change", st(8'd0));
  endtask

  initial begin
    test_reset;
    test_exact_buy;
    test_change;
    test_short_credit;
    test_overflow;
    test_cancel_vs_buy;
    test_idle_corner_cases;
    test_reset_mid_change;
    repeat (2) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
